// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch path.
//   ADDR_W_DEF / DATA_W_DEF : default instruction-memory address / data widths
//   HLT_OPCODE_DEF          : inst[31:27] value that marks a hlt instruction
//   fetch_state_t           : fetch control states
//   fetch_entry_t           : one fetched instruction with its address (also used by IF/OF)
package fetch_pkg;

  localparam int         ADDR_W_DEF     = 7;
  localparam int         DATA_W_DEF     = 32;
  localparam logic [4:0] HLT_OPCODE_DEF = 5'b11111;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    HALT_PEND = 2'd1,
    HALTED    = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] inst;
    logic [ADDR_W_DEF-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bus bundle between the fetch sequencer, instruction memory and the IF/OF register.
//   im_addra/im_en/im_douta      : instruction-memory read port (1-cycle latency)
//   ready_i/redirect_i/_pc_i     : pipeline back-pressure and branch redirect
//   valid_o/inst_o/pc_o/halted_o : fetched instruction handshake and halt status
// master = fetch sequencer side, slave = memory/pipeline side.
interface fetch_sequencer_if #(
  parameter int ADDR_W = fetch_pkg::ADDR_W_DEF,
  parameter int DATA_W = fetch_pkg::DATA_W_DEF
) ();
  logic [ADDR_W-1:0] im_addra;
  logic              im_en;
  logic [DATA_W-1:0] im_douta;
  logic              ready_i;
  logic              redirect_i;
  logic [ADDR_W-1:0] redirect_pc_i;
  logic              valid_o;
  logic [DATA_W-1:0] inst_o;
  logic [ADDR_W-1:0] pc_o;
  logic              halted_o;

  modport master (
    output im_addra, im_en, valid_o, inst_o, pc_o, halted_o,
    input  im_douta, ready_i, redirect_i, redirect_pc_i
  );

  modport slave (
    input  im_addra, im_en, valid_o, inst_o, pc_o, halted_o,
    output im_douta, ready_i, redirect_i, redirect_pc_i
  );
endinterface

// File: rtl/fetch_skid_buffer.sv
// Single-entry holding buffer for a returned instruction that could not go
// straight to the output register.
//   clk, srst : clock, synchronous active-high reset
//   flush     : drop the entry (highest priority after reset)
//   push      : write din and mark valid (may coincide with the entry being
//               read out, in which case the new data simply replaces it)
//   pop       : entry consumed, clear valid
//   valid/dout: current entry
module fetch_skid_buffer #(
  parameter type entry_t = fetch_pkg::fetch_entry_t
) (
  input  logic   clk,
  input  logic   srst,
  input  logic   flush,
  input  logic   push,
  input  logic   pop,
  input  entry_t din,
  output logic   valid,
  output entry_t dout
);

  logic   valid_reg;
  entry_t entry_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      valid_reg <= 1'b0;
      entry_reg <= '0;
    end else if (flush) begin
      valid_reg <= 1'b0;
    end else if (push) begin
      valid_reg <= 1'b1;
      entry_reg <= din;
    end else if (pop) begin
      valid_reg <= 1'b0;
    end
  end

  assign valid = valid_reg;
  assign dout  = entry_reg;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer for the pipelined SimpleRISC core.
// Owns the fetch PC, issues one BRAM read per cycle when there is room,
// absorbs the 1-cycle read latency with a one-entry skid buffer, presents
// instructions with a valid/ready handshake, handles branch redirect and
// stops fetching once a hlt has been accepted downstream.
//   clka : clock (also the instruction-memory clock)
//   rsta : synchronous active-high reset
//   bus  : fetch_sequencer_if.master (memory port, handshake, redirect, halt)
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int               ADDR_W     = ADDR_W_DEF,
  parameter int               DATA_W     = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [4:0]       HLT_OPCODE = HLT_OPCODE_DEF
) (
  input logic                clka,
  input logic                rsta,
  fetch_sequencer_if.master  bus
);

  typedef struct packed {
    logic [DATA_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  fetch_state_t      state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg;
  logic              inflight_v_reg;
  logic [ADDR_W-1:0] inflight_pc_reg;
  logic              out_v_reg;
  entry_t            out_reg;

  logic   skid_v, skid_push, skid_pop, skid_flush;
  entry_t skid_entry, ret_entry, load_entry;
  logic   redirect_take, issue_ok, slot_free, load_out, hlt_load, consume;

  // Redirect is honoured everywhere except once halted.
  assign redirect_take = bus.redirect_i && (state_reg != HALTED);
  // Never issue if the returning data could find both skid and output busy.
  assign issue_ok  = (state_reg == RUN) && !skid_v &&
                     !(out_v_reg && !bus.ready_i && inflight_v_reg);
  assign slot_free = !out_v_reg || bus.ready_i;
  assign consume   = out_v_reg && bus.ready_i;
  assign ret_entry = '{inst: bus.im_douta, pc: inflight_pc_reg};

  // Routing of returned data: skid is older than the BRAM output, so it goes
  // first and the BRAM word takes its place in the skid.
  always_comb begin
    load_out   = 1'b0;
    load_entry = ret_entry;
    skid_push  = 1'b0;
    skid_pop   = 1'b0;
    if (!redirect_take) begin
      if (inflight_v_reg) begin
        if (slot_free) begin
          load_out = 1'b1;
          if (skid_v) begin
            load_entry = skid_entry;
            skid_push  = 1'b1;
          end
        end else begin
          skid_push = 1'b1;
        end
      end else if (slot_free && skid_v) begin
        load_out   = 1'b1;
        load_entry = skid_entry;
        skid_pop   = 1'b1;
      end
    end
  end

  assign hlt_load   = load_out && (state_reg == RUN) &&
                      (load_entry.inst[DATA_W-1 -: 5] == HLT_OPCODE);
  // Anything behind a hlt or a taken branch is on the wrong path.
  assign skid_flush = redirect_take || hlt_load;

  fetch_skid_buffer #(
    .entry_t (entry_t)
  ) u_skid (
    .clk   (clka),
    .srst  (rsta),
    .flush (skid_flush),
    .push  (skid_push),
    .pop   (skid_pop),
    .din   (ret_entry),
    .valid (skid_v),
    .dout  (skid_entry)
  );

  // FSM: state register
  always_ff @(posedge clka) begin
    if (rsta) state_reg <= RUN;
    else      state_reg <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:       if (hlt_load) state_next = HALT_PEND;
      HALT_PEND: begin
        if (redirect_take) state_next = RUN;
        else if (consume)  state_next = HALTED;
      end
      HALTED:    state_next = HALTED;
      default:   state_next = RUN;
    endcase
  end

  // FSM: outputs
  always_comb begin
    bus.im_en    = !rsta && (redirect_take || issue_ok);
    bus.im_addra = redirect_take ? bus.redirect_pc_i : pc_reg;
    bus.halted_o = (state_reg == HALTED);
  end

  // PC, in-flight tracking and output register
  always_ff @(posedge clka) begin
    if (rsta) begin
      pc_reg          <= RESET_PC;
      inflight_v_reg  <= 1'b0;
      inflight_pc_reg <= '0;
      out_v_reg       <= 1'b0;
      out_reg         <= '0;
    end else if (redirect_take) begin
      // A simultaneous handshake is squashed too; downstream flushes it.
      out_v_reg       <= 1'b0;
      inflight_v_reg  <= 1'b1;
      inflight_pc_reg <= bus.redirect_pc_i;
      pc_reg          <= bus.redirect_pc_i + ADDR_W'(1);
    end else begin
      if (load_out) begin
        out_v_reg <= 1'b1;
        out_reg   <= load_entry;
      end else if (consume) begin
        out_v_reg <= 1'b0;
      end
      inflight_v_reg <= issue_ok && !hlt_load;
      if (issue_ok) begin
        inflight_pc_reg <= pc_reg;
        pc_reg          <= pc_reg + ADDR_W'(1);
      end
    end
  end

  assign bus.valid_o = out_v_reg;
  assign bus.inst_o  = out_reg.inst;
  assign bus.pc_o    = out_reg.pc;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences the instruction memory (7-bit word address, 32-bit data, one-cycle synchronous read) for the pipelined SimpleRISC core.
- Owns the fetch PC and issues one read per cycle when the pipeline has room.
- Absorbs the BRAM read latency with a one-entry skid buffer, and presents instructions to the IF/OF register with a valid/ready handshake.
- Handles branch redirect (squashing in-flight reads) and stops fetching after a hlt instruction.

Parameters:
- ADDR_W, 7: instruction-memory word-address width.
- DATA_W, 32: instruction width.
- RESET_PC, 0: first fetch address after reset.
- HLT_OPCODE, 5'b11111: value of inst[31:27] that marks hlt.

Ports:
- clka, in, 1: single clock, also the instruction-memory clock.
- rsta, in, 1: synchronous, active-high reset.
- im_addra, out, ADDR_W: read address to instruction memory. Combinational; meaningful only when im_en=1.
- im_en, out, 1: a read is issued this cycle.
- im_douta, in, DATA_W: memory data, valid the cycle after issue.
- ready_i, in, 1: downstream accepts the output this cycle (not stalled).
- redirect_i, in, 1: branch taken; squash and refetch from redirect_pc_i.
- redirect_pc_i, in, ADDR_W: redirect target.
- valid_o, out, 1: inst_o/pc_o hold a valid instruction.
- inst_o, out, DATA_W: fetched instruction (registered).
- pc_o, out, ADDR_W: address of inst_o (registered).
- halted_o, out, 1: hlt has been accepted downstream; fetch is stopped.

Behaviour:
- Internal registers:
  - pc_q
  - inflight_v, inflight_pc
  - skid_v, skid_inst, skid_pc
  - out_v (= valid_o), inst_o, pc_o
  - state in {RUN, HALT_PEND, HALTED}
- Reset, checked each clka edge while rsta=1:
  - pc_q=RESET_PC; inflight_v=skid_v=out_v=0; inst_o=0; pc_o=0; state=RUN; halted_o=0.
  - im_en=0 while rsta is high.
- Priority: rsta > redirect_i > normal operation. A reset mid-stream discards everything in flight.
- Issue rule (RUN only): im_en = !skid_v && !(out_v && !ready_i && inflight_v).
  - On issue: im_addra=pc_q; at the edge, inflight_v=1, inflight_pc=pc_q, pc_q=pc_q+1 (mod 2^ADDR_W, so 127 wraps to 0).
- Data return: when inflight_v=1, im_douta is captured in the same cycle.
  - If the output slot is free or being accepted (!out_v || ready_i), load the output register from skid if skid_v, else from im_douta. Skid data takes precedence, preserving order.
  - A displaced im_douta moves into skid in that case.
  - Otherwise, im_douta goes to skid. Skid never overflows, guaranteed by the issue rule.
- Output handshake:
  - valid_o/inst_o/pc_o are held stable while valid_o && !ready_i.
  - An entry is consumed on valid_o && ready_i.
- Latency and throughput:
  - Issue in cycle N gives valid_o in cycle N+2.
  - With ready_i held at 1: one instruction per cycle, consecutive pc_o values.
- Redirect (any state except HALTED):
  - Clears out_v, skid_v and inflight_v at the edge. Data returning next cycle from the squashed read is ignored.
  - Same cycle: im_en=1, im_addra=redirect_pc_i. At the edge: inflight_v=1, inflight_pc=redirect_pc_i, pc_q=redirect_pc_i+1, state=RUN.
  - First redirected instruction appears on valid_o two cycles after redirect_i.
- State machine:
  - RUN → HALT_PEND when an instruction with inst[31:27]==HLT_OPCODE is loaded into the output register. At that edge, drop inflight_v and skid_v; no further issue.
  - HALT_PEND → HALTED on the handshake of that hlt (valid_o && ready_i); halted_o=1 at that edge.
  - HALT_PEND → RUN on redirect_i, because an older branch was taken and the hlt was on the wrong path.
  - HALTED is absorbing until rsta: im_en=0, valid_o=0, redirect_i ignored.
- Simultaneous redirect_i and hlt load: redirect wins; state stays RUN.
- Simultaneous ready_i and redirect_i: the current output is treated as squashed (downstream flushes it).

Decomposition:
- Package fetch_pkg holds:
  - ADDR_W and DATA_W defaults
  - HLT_OPCODE
  - the fetch_state_t enum {RUN, HALT_PEND, HALTED}
  - a fetch_entry_t struct {inst, pc}, shared with the IF/OF register
- One natural sub-module: fetch_skid_buffer, a single-entry buffer with valid flag and flush.
- PC logic and the FSM stay in the top module.

Test Plan:
- Reset then ready_i=1, memory word k = k: im_addra 0,1,2… from cycle 1; valid_o from cycle 3 with pc_o=0,1,2… and inst_o==pc_o, one per cycle, no gaps.
- ready_i=0 for 3 cycles while streaming: valid_o/pc_o frozen (say pc_o=4), at most one skid entry, im_en drops. On release: pc_o 4,5,6,7 with no loss or duplicate.
- redirect_i with redirect_pc_i=40 while inflight and skid are full: next valid_o has pc_o=40, none of the squashed addresses ever appear, then 41,42.
- Fetch from pc 126 with ready_i=1: pc_o sequence 126,127,0,1 (wrap).
- hlt at address 5: pc_o 0..5 delivered, then valid_o=0, halted_o=1 after the hlt handshake, im_en=0 forever. A later redirect_i is ignored. rsta then restarts at pc 0.
- hlt at address 5 held with ready_i=0 while redirect_i (target 20) arrives: state returns to RUN, the hlt is not delivered, halted_o stays 0, stream resumes at 20.
